alu_pipe: RTL and testbench

Parametrised, two-stage pipelined successor to the combinational 8-bit ALU. It uses the same MIPS-funct opcode set plus SLL, and adds an illegal-op error bit and status flags. Operands enter and results leave over valid/ready handshakes, so the block can sit between the operand-capture logic and the display/result register with backpressure.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_core.sv | 78 +++++++
 rtl/alu_pipe.sv | 133 +++++++++++++
 tb/tb_alu_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode definitions for the ALU pipeline: opcode constants,
// an enum view of the opcode field and the legality check.
// Optional build macro used by the users of this package: ALU_PIPE_FLAGS_EN.
package alu_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_W-1:0] OP_SLL = 6'b000000;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD = OP_ADD,
    ALU_SUB = OP_SUB,
    ALU_AND = OP_AND,
    ALU_OR  = OP_OR,
    ALU_XOR = OP_XOR,
    ALU_NOR = OP_NOR,
    ALU_SRL = OP_SRL,
    ALU_SRA = OP_SRA,
    ALU_SLL = OP_SLL
  } alu_op_t;

  // True for the nine implemented opcodes; everything else raises err.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_NOR, OP_SRL, OP_SRA, OP_SLL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath sitting between the S1 and S2 registers.
// Carry and overflow ports and logic exist only when ALU_PIPE_FLAGS_EN is
// defined; without it the core produces result, zero and err only.
// The opcode field is expected to be 6 bits wide (N_OP = 6).
module alu_core #(
  parameter int N    = 8,
  parameter int N_OP = 6,
  localparam int SH_W = $clog2(N)
) (
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  input  logic [N_OP-1:0] op,
  output logic [N-1:0]    result,
  output logic            zero,
`ifdef ALU_PIPE_FLAGS_EN
  output logic            carry,
  output logic            overflow,
`endif
  output logic            err
);
  import alu_pkg::*;

  alu_op_t         op_e;
  logic [SH_W-1:0] shamt;

  assign op_e  = alu_op_t'(op);
  // Shift amount is b modulo N: only the low SH_W bits matter.
  assign shamt = b[SH_W-1:0];

`ifdef ALU_PIPE_FLAGS_EN
  // One extra bit holds the carry out of the add and the borrow of the subtract.
  logic [N:0] sum;
  logic [N:0] diff;
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
`endif

  // Opcode decode and datapath; an illegal opcode leaves the result at zero.
  always_comb begin
    result = '0;
`ifdef ALU_PIPE_FLAGS_EN
    carry    = 1'b0;
    overflow = 1'b0;
`endif
    case (op_e)
      ALU_ADD: begin
`ifdef ALU_PIPE_FLAGS_EN
        result   = sum[N-1:0];
        carry    = sum[N];
        overflow = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
`else
        result   = a + b;
`endif
      end
      ALU_SUB: begin
`ifdef ALU_PIPE_FLAGS_EN
        result   = diff[N-1:0];
        carry    = diff[N];
        overflow = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
`else
        result   = a - b;
`endif
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOR: result = ~(a | b);
      ALU_SRL: result = a >> shamt;
      ALU_SRA: result = $signed(a) >>> shamt;
      ALU_SLL: result = a << shamt;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign err  = !is_legal_op(OP_W'(op));

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides.
// S1 registers operands and opcode; S2 registers the alu_core outputs.
// Optional macro ALU_PIPE_FLAGS_EN: when defined, carry and overflow are
// computed and registered in S2; otherwise out_carry/out_overflow are tied 0.
//
// Handshake: a beat transfers on a rising edge where valid && ready.
// in_ready = !s1_valid || s2_adv is combinational from out_ready. While
// out_valid && !out_ready, result, flags and out_valid hold stable.
module alu_pipe #(
  parameter int N    = 8,
  parameter int N_OP = 6,
  localparam int SH_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    date_a,
  input  logic [N-1:0]    date_b,
  input  logic [N_OP-1:0] op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    result,
  output logic            out_zero,
  output logic            out_carry,
  output logic            out_overflow,
  output logic            out_err
);
  import alu_pkg::*;

  // S1 registers
  logic            s1_valid;
  logic [N-1:0]    s1_a;
  logic [N-1:0]    s1_b;
  logic [N_OP-1:0] s1_op;

  // S2 registers
  logic            s2_valid;
  logic [N-1:0]    s2_result;
  logic            s2_zero;
  logic            s2_err;

  // Combinational core outputs
  logic [N-1:0]    core_result;
  logic            core_zero;
  logic            core_err;

  logic            s2_adv;
  logic            s1_adv;

  // S2 moves when empty or when downstream takes its beat; S1 follows S2.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = s2_adv;
  assign in_ready = !s1_valid || s1_adv;

  // S1: capture operands whenever the stage can accept (bubble if !in_valid).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      s1_a     <= date_a;
      s1_b     <= date_b;
      s1_op    <= op;
    end
  end

`ifdef ALU_PIPE_FLAGS_EN
  logic core_carry;
  logic core_overflow;
  logic s2_carry;
  logic s2_overflow;
`endif

  alu_core #(
    .N    (N),
    .N_OP (N_OP)
  ) u_core (
    .a        (s1_a),
    .b        (s1_b),
    .op       (s1_op),
    .result   (core_result),
    .zero     (core_zero),
`ifdef ALU_PIPE_FLAGS_EN
    .carry    (core_carry),
    .overflow (core_overflow),
`endif
    .err      (core_err)
  );

  // S2: register core outputs when advancing; hold everything while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_zero   <= 1'b0;
      s2_err    <= 1'b0;
    end else if (s2_adv) begin
      s2_valid  <= s1_valid;
      s2_result <= core_result;
      s2_zero   <= core_zero;
      s2_err    <= core_err;
    end
  end

`ifdef ALU_PIPE_FLAGS_EN
  // S2 carry/overflow flags, advancing in lockstep with the rest of S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_carry    <= 1'b0;
      s2_overflow <= 1'b0;
    end else if (s2_adv) begin
      s2_carry    <= core_carry;
      s2_overflow <= core_overflow;
    end
  end

  assign out_carry    = s2_carry;
  assign out_overflow = s2_overflow;
`else
  assign out_carry    = 1'b0;
  assign out_overflow = 1'b0;
`endif

  assign out_valid = s2_valid;
  assign result    = s2_result;
  assign out_zero  = s2_zero;
  assign out_err   = s2_err;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (N = 8): directed vector table, handshake
// corner sequences (backpressure, asynchronous reset) and a randomized
// stream checked by a scoreboard fed from an arithmetic reference model.
// Works with or without ALU_PIPE_FLAGS_EN defined.
module tb_alu_pipe;

  localparam int N = 8;
`ifdef ALU_PIPE_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] date_a;
  logic [N-1:0] date_b;
  logic [5:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         out_zero;
  logic         out_carry;
  logic         out_overflow;
  logic         out_err;

  alu_pipe #(.N(N), .N_OP(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .date_a       (date_a),
    .date_b       (date_b),
    .op           (op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .out_zero     (out_zero),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .out_err      (out_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int n_out = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model from the arithmetic rules: returns {result, zero, carry, ovf, err}.
  function automatic logic [11:0] ref_model(input logic [5:0] o, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, s, r, sh;
    logic c, v, e;
    ua = a; ub = b;
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    sh = ub % 8;
    r = 0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (o)
      6'b100000: begin r = ua + ub; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); r = r % 256; end
      6'b100010: begin r = (ua - ub + 256) % 256; c = (ua < ub); s = sa - sb; v = (s > 127) || (s < -128); end
      6'b100100: r = ua & ub;
      6'b100101: r = ua | ub;
      6'b100110: r = ua ^ ub;
      6'b100111: r = 255 - (ua | ub);
      6'b000010: r = ua >> sh;
      6'b000011: r = (sa >>> sh) & 255;
      6'b000000: r = (ua << sh) % 256;
      default:   e = 1'b1;
    endcase
    if (!FLAGS) begin c = 1'b0; v = 1'b0; end
    return {r[7:0], (r == 0), c, v, e};
  endfunction

  // Scoreboard monitor: handshakes are decided by values stable at the negedge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("scoreboard", {20'd0, result, out_zero, out_carry, out_overflow, out_err}, {20'd0, mon_exp});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(op, date_a, date_b));
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [5:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       v;
    logic       e;
  } vec_t;

  vec_t vecs[17];

  // Single beat through an idle pipe with out_ready high; checks 2-cycle latency.
  task automatic run_vec(input int idx, input vec_t v);
    @(posedge clk); #1;
    op = v.op; date_a = v.a; date_b = v.b; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_in_ready", idx), {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_early_valid", idx), {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d_valid", idx),  {31'd0, out_valid},    32'd1);
    chk($sformatf("v%0d_result", idx), {24'd0, result},       {24'd0, v.res});
    chk($sformatf("v%0d_zero", idx),   {31'd0, out_zero},     {31'd0, v.z});
    chk($sformatf("v%0d_carry", idx),  {31'd0, out_carry},    {31'd0, v.c & FLAGS});
    chk($sformatf("v%0d_ovf", idx),    {31'd0, out_overflow}, {31'd0, v.v & FLAGS});
    chk($sformatf("v%0d_err", idx),    {31'd0, out_err},      {31'd0, v.e});
  endtask

  task automatic drive(input logic [5:0] o, input logic [7:0] a, input logic [7:0] b);
    op = o; date_a = a; date_b = b; in_valid = 1'b1;
  endtask

  logic [5:0] op_list[9];

  // ---------------- main sequence ----------------
  initial begin
    int n0, sent, cyc;
    logic acc;

    vecs[0]  = '{6'b100000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{6'b100010, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{6'b100010, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{6'b000010, 8'hFF, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{6'b000011, 8'hFF, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{6'b000000, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{6'b000010, 8'hFF, 8'h09, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{6'b111111, 8'h05, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{6'b100100, 8'h0F, 8'h3C, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{6'b100101, 8'h0F, 8'h3C, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{6'b100110, 8'h0F, 8'h3C, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{6'b100111, 8'h0F, 8'h3C, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{6'b100000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{6'b000011, 8'h80, 8'h07, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{6'b000011, 8'h40, 8'h02, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{6'b100010, 8'h55, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{6'b000001, 8'hAA, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};

    op_list[0] = 6'b100000; op_list[1] = 6'b100010; op_list[2] = 6'b100100;
    op_list[3] = 6'b100101; op_list[4] = 6'b100110; op_list[5] = 6'b100111;
    op_list[6] = 6'b000010; op_list[7] = 6'b000011; op_list[8] = 6'b000000;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    date_a = '0; date_b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid},    32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},     32'd1);
    chk("rst_result",    {24'd0, result},       32'd0);
    chk("rst_zero",      {31'd0, out_zero},     32'd0);
    chk("rst_carry",     {31'd0, out_carry},    32'd0);
    chk("rst_ovf",       {31'd0, out_overflow}, 32'd0);
    chk("rst_err",       {31'd0, out_err},      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);
    @(posedge clk); #1;

    // Backpressure: four back-to-back ADDs, stall once the first result shows.
    n0 = n_out;
    out_ready = 1'b1;
    drive(6'b100000, 8'h10, 8'h20);
    @(posedge clk); #1; drive(6'b100000, 8'h30, 8'h40);
    @(posedge clk); #1; drive(6'b100000, 8'h50, 8'h60); out_ready = 1'b0;
    @(negedge clk);
    chk("bp_first_valid",  {31'd0, out_valid}, 32'd1);
    chk("bp_first_result", {24'd0, result},    32'h30);
    chk("bp_in_ready_low", {31'd0, in_ready},  32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_stall_valid",    {31'd0, out_valid}, 32'd1);
      chk("bp_stall_result",   {24'd0, result},    32'h30);
      chk("bp_stall_in_ready", {31'd0, in_ready},  32'd0);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; drive(6'b100000, 8'h7F, 8'h01);
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("bp_queue_empty", exp_q.size(), 32'd0);
    chk("bp_count",       n_out - n0,   32'd4);
    chk("bp_idle",        {31'd0, out_valid}, 32'd0);

    // Asynchronous reset with both stages full.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(6'b100000, 8'h11, 8'h22);
    @(posedge clk); #1; drive(6'b100010, 8'h33, 8'h01);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("ar_full_valid",    {31'd0, out_valid}, 32'd1);
    chk("ar_full_in_ready", {31'd0, in_ready},  32'd0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_in_ready",  {31'd0, in_ready},  32'd1);
    chk("ar_result",    {24'd0, result},    32'd0);
    chk("ar_err",       {31'd0, out_err},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ar_post_valid",    {31'd0, out_valid}, 32'd0);
    chk("ar_post_in_ready", {31'd0, in_ready},  32'd1);
    run_vec(100, '{6'b100000, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0});

    // Randomized stream with random bubbles and backpressure.
    sent = 0; cyc = 0; acc = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (sent < 150 && cyc < 4000) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
        else op = op_list[$urandom_range(0, 8)];
        date_a = 8'($urandom_range(0, 255));
        date_b = 8'($urandom_range(0, 255));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_sent", sent, 32'd150);
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(negedge clk);
    chk("rand_drain_q",     exp_q.size(), 32'd0);
    chk("rand_drain_valid", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
